multi_counter: RTL and testbench
================================

Name: multi_counter

Overview:
- Parametrised multi-channel successor to the single-channel rollover counter.
- Provides NUM_CH independent counters, each with:
  - its own rollover value
  - selectable up/down direction
  - synchronous load and clear
  - a level terminal flag and a one-cycle wrap pulse
- Used by control/timeout logic that needs several programmable interval counters in one clock domain.
- All per-channel buses are packed, with channel 0 in the LSBs.

Parameters:
- NUM_CH, 4, number of independent counter channels (>=1).
- NUM_CNT_BITS, 8, width of each channel's counter.
- PRESCALE_DIV, 4, shared prescaler divide ratio (>=1). Used only when CNT_PRESCALE_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- clear  input  NUM_CH  per-channel synchronous clear.
- load  input  NUM_CH  per-channel synchronous load.
- load_val  input  NUM_CH*NUM_CNT_BITS  per-channel load value.
- count_enable  input  NUM_CH  per-channel count enable.
- dir  input  NUM_CH  per-channel direction: 0 = up, 1 = down.
- rollover_val  input  NUM_CH*NUM_CNT_BITS  per-channel terminal value.
- count_out  output  NUM_CH*NUM_CNT_BITS  registered per-channel count.
- rollover_flag  output  NUM_CH  registered level: count_out equals the channel's terminal value.
- wrap_pulse  output  NUM_CH  registered one-cycle pulse marking a wrap.
- any_wrap  output  1  registered OR of the wrap conditions of all channels.

Behaviour:
- Reset: while rst=1 (asynchronous), count_out=0, rollover_flag=0, wrap_pulse=0, any_wrap=0, prescaler=0. First update occurs on the first rising clk after rst deasserts.
- Channels are fully independent. All outputs are registered; inputs sampled at edge N appear on outputs after edge N (latency 1).
- Per-channel priority, evaluated each edge: clear > load > count > hold.
  - clear: next=0, no wrap.
  - load: next=load_val, no wrap. Any value is accepted, including values > rollover_val.
  - count (count_enable=1 and, if enabled, prescaler tick):
    - Up (dir=0): if count >= rollover_val, next=0 and wrap; else next=count+1.
    - Down (dir=1): if count == 0, next=rollover_val and wrap; else next=count-1.
  - hold: next=count, no wrap.
- Terminal value is rollover_val for up and 0 for down, using the dir and rollover_val present in the same cycle.
- rollover_flag registers (next == terminal value). It is therefore high while the counter sits at its terminal value, including after clear or load to that value.
- wrap_pulse registers the wrap condition. It is high for exactly one cycle per wrap event and stays high on consecutive edges only if wrap repeats.
- rollover_val=0:
  - Up mode wraps to 0 on every enabled cycle.
  - Down mode stays at 0 and wraps on every enabled cycle.
  - rollover_flag stays 1 in both modes.
- Width rule: arithmetic is modulo 2^NUM_CNT_BITS. The up comparison (>=) prevents natural overflow unless rollover_val = 2^NUM_CNT_BITS-1.
- Changing dir or rollover_val mid-count takes effect on the next edge. No state is kept beyond count_out.
- Reset asserted mid-count forces all outputs to 0 immediately, without waiting for clk.

Optional Feature:
- Macro: CNT_PRESCALE_EN
- Defined:
  - A shared prescaler counts 0..PRESCALE_DIV-1 freely from reset. tick=1 when prescaler==PRESCALE_DIV-1.
  - The count action requires count_enable && tick.
  - clear and load remain immediate, every cycle.
  - The prescaler ignores clear and load and resets only on rst.
  - PRESCALE_DIV=1 gives tick=1 constantly.
- Not defined: no prescaler logic. count_enable acts on every edge.

Test Plan:
- Reset/basic up: rst pulse, ch0 rollover_val=3, dir=0, enable=1 -> count_out 0,1,2,3,0,1. rollover_flag=1 while count=3. wrap_pulse=1 for one cycle when count returns to 0. any_wrap matches.
- Down mode: ch1 rollover_val=5, dir=1, load_val=2 with load=1 for one cycle, then enable -> 2,1,0,5,4. wrap_pulse on the 0->5 edge. rollover_flag=1 while count=0.
- Priority: assert clear, load(load_val=7) and enable together on ch2 at count=4 -> next=0. Then load+enable -> next=7, no wrap.
- Out-of-range/boundary: NUM_CNT_BITS=8, load ch3=200 with rollover_val=10, up -> next=0 with wrap. rollover_val=255 -> 254,255,0 with wrap. rollover_val=0 -> stays 0, wrap_pulse every enabled cycle.
- Async reset mid-operation: drive all channels counting, assert rst between edges -> all outputs 0 before the next edge. Counting resumes from 0 after release.
- CNT_PRESCALE_EN, PRESCALE_DIV=4: enable held, rollover_val=2 -> count advances once per 4 clocks (0,1,2,0). A load asserted between ticks applies on the next edge.

Source files
------------

// File: rtl/multi_counter_if.sv
// multi_counter_if: bundles the per-channel control, data and status buses
// of multi_counter. All buses are packed with channel 0 in the LSBs.
//   master : drives clear/load/load_val/count_enable/dir/rollover_val,
//            observes count_out/rollover_flag/wrap_pulse/any_wrap
//   slave  : the counter block itself (mirror directions)
interface multi_counter_if #(
  parameter int NUM_CH       = 4,
  parameter int NUM_CNT_BITS = 8
);
  logic [NUM_CH-1:0]              clear;
  logic [NUM_CH-1:0]              load;
  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CH-1:0]              count_enable;
  logic [NUM_CH-1:0]              dir;
  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
  logic [NUM_CH-1:0]              rollover_flag;
  logic [NUM_CH-1:0]              wrap_pulse;
  logic                           any_wrap;

  modport master (
    output clear, load, load_val, count_enable, dir, rollover_val,
    input  count_out, rollover_flag, wrap_pulse, any_wrap
  );

  modport slave (
    input  clear, load, load_val, count_enable, dir, rollover_val,
    output count_out, rollover_flag, wrap_pulse, any_wrap
  );
endinterface

// File: rtl/multi_counter.sv
// multi_counter: NUM_CH independent rollover counters in one clock domain.
// Each channel: clear > load > count > hold, up/down direction, a level
// terminal flag (count at rollover_val for up, at 0 for down) and a
// one-cycle wrap pulse. any_wrap is the registered OR of all wrap events.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - multi_counter_if.slave (all per-channel control/status buses)
// Optional feature macro CNT_PRESCALE_EN: a free-running shared prescaler
// gates counting to once every PRESCALE_DIV clocks; clear/load stay
// immediate. Without the macro, counting happens on every enabled edge.
module multi_counter #(
  parameter int NUM_CH       = 4,
  parameter int NUM_CNT_BITS = 8,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  multi_counter_if.slave   bus
);
  localparam int W = NUM_CNT_BITS;

  logic [NUM_CH*W-1:0] count_q, count_d;
  logic [NUM_CH-1:0]   flag_q, flag_d;
  logic [NUM_CH-1:0]   wrap_q, wrap_d;
  logic                any_wrap_q, any_wrap_d;
  logic                tick_s;

`ifdef CNT_PRESCALE_EN
  localparam int PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  // Tick on the last prescaler state; PRESCALE_DIV=1 pins ps_q at 0 so tick is constant.
  assign tick_s = (ps_q == PS_LAST);

  // Prescaler next state: free-running 0..PRESCALE_DIV-1, unaffected by clear/load.
  always_comb begin
    ps_d = ps_q;
    if (tick_s) begin
      ps_d = {PS_W{1'b0}};
    end else begin
      ps_d = ps_q + PS_W'(1'b1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= {PS_W{1'b0}};
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  // No prescaler: every enabled edge counts (any legal divider is positive).
  assign tick_s = (PRESCALE_DIV > 0);
`endif

  // Per-channel next count, terminal flag and wrap condition.
  always_comb begin
    logic [W-1:0] cur_s;
    logic [W-1:0] rv_s;
    logic [W-1:0] nxt_s;
    logic [W-1:0] term_s;
    logic         wrap_s;
    count_d    = count_q;
    flag_d     = {NUM_CH{1'b0}};
    wrap_d     = {NUM_CH{1'b0}};
    any_wrap_d = 1'b0;
    cur_s      = {W{1'b0}};
    rv_s       = {W{1'b0}};
    nxt_s      = {W{1'b0}};
    term_s     = {W{1'b0}};
    wrap_s     = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cur_s  = count_q[ch*W +: W];
      rv_s   = bus.rollover_val[ch*W +: W];
      nxt_s  = cur_s;
      wrap_s = 1'b0;
      if (bus.clear[ch]) begin
        nxt_s = {W{1'b0}};
      end else if (bus.load[ch]) begin
        nxt_s = bus.load_val[ch*W +: W];
      end else if (bus.count_enable[ch] && tick_s) begin
        if (!bus.dir[ch]) begin
          // >= (not ==) so a loaded value above rollover_val wraps instead of running on.
          if (cur_s >= rv_s) begin
            nxt_s  = {W{1'b0}};
            wrap_s = 1'b1;
          end else begin
            nxt_s = cur_s + W'(1'b1);
          end
        end else begin
          if (cur_s == {W{1'b0}}) begin
            nxt_s  = rv_s;
            wrap_s = 1'b1;
          end else begin
            nxt_s = cur_s - W'(1'b1);
          end
        end
      end else begin
        nxt_s = cur_s;
      end
      // Terminal value follows the direction sampled in this same cycle.
      if (bus.dir[ch]) begin
        term_s = {W{1'b0}};
      end else begin
        term_s = rv_s;
      end
      count_d[ch*W +: W] = nxt_s;
      flag_d[ch]         = (nxt_s == term_s);
      wrap_d[ch]         = wrap_s;
    end
    any_wrap_d = |wrap_d;
  end

  // Output registers for counts, flags and wrap pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= {(NUM_CH*W){1'b0}};
      flag_q     <= {NUM_CH{1'b0}};
      wrap_q     <= {NUM_CH{1'b0}};
      any_wrap_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      flag_q     <= flag_d;
      wrap_q     <= wrap_d;
      any_wrap_q <= any_wrap_d;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.wrap_pulse    = wrap_q;
  assign bus.any_wrap      = any_wrap_q;
endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: directed plus randomized stimulus for multi_counter,
// checked every cycle against a behavioural reference model.
module tb_multi_counter;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Reference model state (plain integers).
  int m_cnt  [NCH];
  bit m_flag [NCH];
  bit m_wrap [NCH];
  bit m_any;
  int m_ps;

  multi_counter_if #(.NUM_CH(NCH), .NUM_CNT_BITS(W)) mc_if ();

  multi_counter #(.NUM_CH(NCH), .NUM_CNT_BITS(W), .PRESCALE_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_cnt[ch]  = 0;
      m_flag[ch] = 1'b0;
      m_wrap[ch] = 1'b0;
    end
    m_any = 1'b0;
    m_ps  = 0;
  endtask

  // Apply one clock edge of the counting rules to the model.
  task automatic model_edge();
    int rv, n, term;
    bit w, tick;
    tick = 1'b1;
`ifdef CNT_PRESCALE_EN
    tick = (m_ps == DIV - 1);
    m_ps = (m_ps + 1) % DIV;
`endif
    m_any = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      rv = int'(mc_if.rollover_val[ch*W +: W]);
      n  = m_cnt[ch];
      w  = 1'b0;
      if (mc_if.clear[ch]) n = 0;
      else if (mc_if.load[ch]) n = int'(mc_if.load_val[ch*W +: W]);
      else if (mc_if.count_enable[ch] && tick) begin
        if (mc_if.dir[ch] == 1'b0) begin
          if (m_cnt[ch] >= rv) begin n = 0; w = 1'b1; end
          else n = m_cnt[ch] + 1;
        end else begin
          if (m_cnt[ch] == 0) begin n = rv; w = 1'b1; end
          else n = m_cnt[ch] - 1;
        end
      end
      term       = mc_if.dir[ch] ? 0 : rv;
      m_cnt[ch]  = n % (1 << W);
      m_flag[ch] = (m_cnt[ch] == term);
      m_wrap[ch] = w;
      m_any      = m_any | w;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_model(input string tag);
    logic [NCH*W-1:0] ec;
    logic [NCH-1:0]   ef, ew;
    for (int ch = 0; ch < NCH; ch++) begin
      ec[ch*W +: W] = W'(m_cnt[ch]);
      ef[ch]        = m_flag[ch];
      ew[ch]        = m_wrap[ch];
    end
    tests++;
    assert (mc_if.count_out === ec) else begin
      fails++;
      $error("FAIL %s count_out observed=%h expected=%h", tag, mc_if.count_out, ec);
    end
    tests++;
    assert (mc_if.rollover_flag === ef) else begin
      fails++;
      $error("FAIL %s rollover_flag observed=%b expected=%b", tag, mc_if.rollover_flag, ef);
    end
    tests++;
    assert (mc_if.wrap_pulse === ew) else begin
      fails++;
      $error("FAIL %s wrap_pulse observed=%b expected=%b", tag, mc_if.wrap_pulse, ew);
    end
    tests++;
    assert (mc_if.any_wrap === m_any) else begin
      fails++;
      $error("FAIL %s any_wrap observed=%b expected=%b", tag, mc_if.any_wrap, m_any);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cnt"},  int'(mc_if.count_out),     0);
    chk({tag, "_flag"}, int'(mc_if.rollover_flag), 0);
    chk({tag, "_wrap"}, int'(mc_if.wrap_pulse),    0);
    chk({tag, "_any"},  int'(mc_if.any_wrap),      0);
  endtask

  task automatic cfg(input int ch, input bit en, input bit d, input int rv);
    mc_if.count_enable[ch]       = en;
    mc_if.dir[ch]                = d;
    mc_if.rollover_val[ch*W +: W] = W'(rv);
  endtask

  task automatic do_load(input int ch, input bit ld, input int lv);
    mc_if.load[ch]            = ld;
    mc_if.load_val[ch*W +: W] = W'(lv);
  endtask

  function automatic int cnt_of(input int ch);
    return int'(mc_if.count_out[ch*W +: W]);
  endfunction

  initial begin
    int exp_cnt [5];
    int exp_flg [5];
    int exp_wrp [5];
    exp_cnt = '{1, 2, 3, 0, 1};
    exp_flg = '{0, 0, 1, 0, 0};
    exp_wrp = '{0, 0, 0, 1, 0};

    rst                = 1'b1;
    mc_if.clear        = '0;
    mc_if.load         = '0;
    mc_if.load_val     = '0;
    mc_if.count_enable = '0;
    mc_if.dir          = '0;
    mc_if.rollover_val = '0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic up count on ch0, rollover 3.
    cfg(0, 1'b1, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      step("up_ch0");
`ifndef CNT_PRESCALE_EN
      chk("up_ch0_cnt",  cnt_of(0), exp_cnt[i]);
      chk("up_ch0_flag", int'(mc_if.rollover_flag[0]), exp_flg[i]);
      chk("up_ch0_wrap", int'(mc_if.wrap_pulse[0]), exp_wrp[i]);
      chk("up_ch0_any",  int'(mc_if.any_wrap), exp_wrp[i]);
`endif
    end
    cfg(0, 1'b0, 1'b0, 3);

    // Down count on ch1 from a loaded 2, rollover 5.
    cfg(1, 1'b0, 1'b1, 5);
    do_load(1, 1'b1, 2);
    step("down_load");
    do_load(1, 1'b0, 0);
    cfg(1, 1'b1, 1'b1, 5);
    for (int i = 0; i < 4; i++) step("down_ch1");
`ifndef CNT_PRESCALE_EN
    chk("down_ch1_cnt", cnt_of(1), 4);
`endif
    cfg(1, 1'b0, 1'b1, 5);

    // Priority on ch2: clear beats load beats count.
    cfg(2, 1'b1, 1'b0, 20);
    for (int i = 0; i < 4; i++) step("prio_cnt");
    mc_if.clear[2] = 1'b1;
    do_load(2, 1'b1, 7);
    step("prio_clear");
`ifndef CNT_PRESCALE_EN
    chk("prio_clear_cnt", cnt_of(2), 0);
`endif
    mc_if.clear[2] = 1'b0;
    step("prio_load");
`ifndef CNT_PRESCALE_EN
    chk("prio_load_cnt",  cnt_of(2), 7);
    chk("prio_load_wrap", int'(mc_if.wrap_pulse[2]), 0);
`endif
    do_load(2, 1'b0, 0);
    cfg(2, 1'b0, 1'b0, 20);

    // Boundaries on ch3.
    cfg(3, 1'b0, 1'b0, 10);
    do_load(3, 1'b1, 200);
    step("oor_load");
    do_load(3, 1'b0, 0);
    cfg(3, 1'b1, 1'b0, 10);
    step("oor_wrap");
`ifndef CNT_PRESCALE_EN
    chk("oor_wrap_cnt",  cnt_of(3), 0);
    chk("oor_wrap_pls",  int'(mc_if.wrap_pulse[3]), 1);
`endif
    cfg(3, 1'b0, 1'b0, 255);
    do_load(3, 1'b1, 254);
    step("max_load");
    do_load(3, 1'b0, 0);
    cfg(3, 1'b1, 1'b0, 255);
    step("max_255");
    step("max_wrap");
`ifndef CNT_PRESCALE_EN
    chk("max_wrap_cnt", cnt_of(3), 0);
    chk("max_wrap_pls", int'(mc_if.wrap_pulse[3]), 1);
`endif
    cfg(3, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step("rv0_up");
`ifndef CNT_PRESCALE_EN
      chk("rv0_up_wrap", int'(mc_if.wrap_pulse[3]), 1);
      chk("rv0_up_flag", int'(mc_if.rollover_flag[3]), 1);
`endif
    end
    cfg(3, 1'b1, 1'b1, 0);
    for (int i = 0; i < 2; i++) step("rv0_down");
    cfg(3, 1'b0, 1'b0, 0);

`ifdef CNT_PRESCALE_EN
    // Prescaled counting on ch0 with a load landing between ticks.
    mc_if.clear[0] = 1'b1;
    step("ps_clear");
    mc_if.clear[0] = 1'b0;
    cfg(0, 1'b1, 1'b0, 2);
    for (int i = 0; i < 13; i++) step("ps_count");
    do_load(0, 1'b1, 1);
    step("ps_load");
    do_load(0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step("ps_after");
`endif

    // Randomized traffic across all channels.
    for (int i = 0; i < 250; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        mc_if.clear[ch] = ($urandom_range(15) == 0);
        do_load(ch, ($urandom_range(11) == 0), $urandom_range(255));
        cfg(ch, ($urandom_range(3) != 0), $urandom_range(1) == 1,
            ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(6));
      end
      step("rand");
    end

    // Asynchronous reset mid-count.
    mc_if.clear = '0;
    mc_if.load  = '0;
    for (int ch = 0; ch < NCH; ch++) cfg(ch, 1'b1, 1'b0, 50);
    for (int i = 0; i < 3; i++) step("pre_arst");
    #2;
    rst = 1'b1;
    #1;
    check_zero("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("post_arst");
`ifndef CNT_PRESCALE_EN
    chk("post_arst_cnt", cnt_of(2), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
